// File: rtl/video_mode_ctrl.sv
// Runtime timing-mode controller: validates a requested video timing, applies it on a
// frame boundary with a generator restart, then holds the output blanked for a few frames.
module video_mode_ctrl #(
    parameter logic [10:0] DEF_COL_TOTAL  = 11'd90,
    parameter logic [10:0] DEF_COL_ACTIVE = 11'd80,
    parameter logic [10:0] DEF_ROW_TOTAL  = 11'd70,
    parameter logic [10:0] DEF_ROW_ACTIVE = 11'd60,
    parameter logic [3:0]  BLANK_FRAMES   = 4'd2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [10:0] req_col_total_i,
    input  logic [10:0] req_col_active_i,
    input  logic [10:0] req_row_total_i,
    input  logic [10:0] req_row_active_i,
    input  logic        frame_end_i,
    output logic [10:0] cfg_col_total_o,
    output logic [10:0] cfg_col_active_o,
    output logic [10:0] cfg_row_total_o,
    output logic [10:0] cfg_row_active_o,
    output logic        gen_restart_o,
    output logic        blank_o,
    output logic        busy_o,
    output logic        err_o
);

    typedef enum logic [1:0] {RUN, WAIT_EOF, APPLY, BLANK} state_t;

    localparam state_t     RESET_STATE = (BLANK_FRAMES == 4'd0) ? RUN : BLANK;
    localparam logic [3:0] LAST_BLANK  = BLANK_FRAMES - 4'd1;

    state_t      state, next_state;
    logic [3:0]  blank_cnt, next_blank_cnt;
    logic [10:0] sh_col_total, sh_col_active, sh_row_total, sh_row_active;
    logic        accept, req_ok;

    assign accept = req_valid_i && req_ready_o;
    assign req_ok = (req_col_active_i != 11'd0) && (req_col_active_i < req_col_total_i) &&
                    (req_row_active_i != 11'd0) && (req_row_active_i < req_row_total_i) &&
                    (req_col_total_i >= 11'd2)  && (req_row_total_i >= 11'd2);

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        next_blank_cnt = blank_cnt;
        case (state)
            RUN:      if (accept && req_ok) next_state = WAIT_EOF;
            WAIT_EOF: if (frame_end_i) next_state = APPLY;
            APPLY: begin
                next_state     = (BLANK_FRAMES == 4'd0) ? RUN : BLANK;
                next_blank_cnt = 4'd0;
            end
            BLANK: begin
                if (frame_end_i) begin
                    if (blank_cnt == LAST_BLANK) begin
                        next_state     = RUN;
                        next_blank_cnt = 4'd0;
                    end else begin
                        next_blank_cnt = blank_cnt + 4'd1;
                    end
                end
            end
            default:  next_state = RESET_STATE;
        endcase
    end

    // Outputs are decoded from next_state into flops so they change in lockstep with state.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= RESET_STATE;
            blank_cnt     <= 4'd0;
            req_ready_o   <= (RESET_STATE == RUN);
            busy_o        <= (RESET_STATE != RUN);
            blank_o       <= (RESET_STATE != RUN);
            gen_restart_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state         <= next_state;
            blank_cnt     <= next_blank_cnt;
            req_ready_o   <= (next_state == RUN);
            busy_o        <= (next_state != RUN);
            blank_o       <= (next_state == APPLY) || (next_state == BLANK);
            gen_restart_o <= (next_state == APPLY);
            err_o         <= accept && !req_ok;
        end
    end

    // NOTE: the shadow is reset too, so a request pending at reset can never reach cfg_*.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_col_total  <= DEF_COL_TOTAL;
            sh_col_active <= DEF_COL_ACTIVE;
            sh_row_total  <= DEF_ROW_TOTAL;
            sh_row_active <= DEF_ROW_ACTIVE;
        end else if (accept) begin
            sh_col_total  <= req_col_total_i;
            sh_col_active <= req_col_active_i;
            sh_row_total  <= req_row_total_i;
            sh_row_active <= req_row_active_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_col_total_o  <= DEF_COL_TOTAL;
            cfg_col_active_o <= DEF_COL_ACTIVE;
            cfg_row_total_o  <= DEF_ROW_TOTAL;
            cfg_row_active_o <= DEF_ROW_ACTIVE;
        end else if (state == APPLY) begin
            cfg_col_total_o  <= sh_col_total;
            cfg_col_active_o <= sh_col_active;
            cfg_row_total_o  <= sh_row_total;
            cfg_row_active_o <= sh_row_active;
        end
    end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
Runtime controller for the runtime-configurable video timing generator. Accepts a timing-change request over a valid/ready handshake and validates it. Applies it only on a frame boundary by updating the generator's timing configuration and restarting its counters. Forces black output for a programmable number of frames after reset and after every mode change, so the downstream HDMI/VGA sink resynchronises cleanly.

Parameters:
DEF_COL_TOTAL, 11'd90, column total applied at reset
DEF_COL_ACTIVE, 11'd80, active columns applied at reset
DEF_ROW_TOTAL, 11'd70, row total applied at reset
DEF_ROW_ACTIVE, 11'd60, active rows applied at reset
BLANK_FRAMES, 4'd2, frames of forced blanking after reset/change (0..15)

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  new timing request valid
req_ready_o  out  1  controller can accept a request
req_col_total_i  in  11  requested column total
req_col_active_i  in  11  requested active columns
req_row_total_i  in  11  requested row total
req_row_active_i  in  11  requested active rows
frame_end_i  in  1  one-cycle pulse from generator on last pixel of a frame
cfg_col_total_o  out  11  applied column total
cfg_col_active_o  out  11  applied active columns
cfg_row_total_o  out  11  applied row total
cfg_row_active_o  out  11  applied active rows
gen_restart_o  out  1  one-cycle pulse: generator clears row/col counters to 0
blank_o  out  1  force pixel output to 12'h000 and de to 0
busy_o  out  1  change in progress (not in RUN)
err_o  out  1  one-cycle pulse: request rejected

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low, rst_ni. All state registers clear on rst_ni=0, independent of clk_i.
- Reset values:
  - cfg_* = DEF_*
  - state = BLANK, blank counter = 0
  - req_ready_o=0, busy_o=1, blank_o=1, gen_restart_o=0, err_o=0
  - if BLANK_FRAMES==0, reset state is RUN (busy_o=0, blank_o=0, req_ready_o=1)
- States: RUN, WAIT_EOF, APPLY, BLANK.
- RUN:
  - req_ready_o=1, busy_o=0, blank_o=0.
  - Handshake completes when req_valid_i && req_ready_o. Request fields are captured into a shadow register in that cycle.
  - Validity rule, all must hold: 0 < active < total for both axes; col_total >= 2; row_total >= 2.
  - Valid request -> WAIT_EOF next cycle.
  - Invalid request -> stay RUN; err_o=1 the next cycle for exactly one cycle; cfg_* unchanged.
- WAIT_EOF:
  - req_ready_o=0, busy_o=1, blank_o=0.
  - frame_end_i asserted in the acceptance cycle is ignored; only a frame_end_i seen while in WAIT_EOF counts.
  - On frame_end_i -> APPLY.
- APPLY (exactly one cycle):
  - cfg_* <= shadow, visible from the next cycle.
  - gen_restart_o=1 during this cycle, blank_o=1.
  - Next state: BLANK, or RUN if BLANK_FRAMES==0.
- BLANK:
  - blank_o=1, busy_o=1, req_ready_o=0.
  - 4-bit counter increments on each frame_end_i.
  - When frame_end_i arrives with counter == BLANK_FRAMES-1: clear counter and go to RUN. blank_o deasserts in the cycle after that frame_end_i.
- Requests during WAIT_EOF/APPLY/BLANK are not accepted (ready=0); requester holds valid. No queuing; at most one change in flight.
- All outputs registered; no combinational path from req_*_i or frame_end_i to any output.
- No timeout: WAIT_EOF and BLANK wait indefinitely for frame_end_i.
- Reset mid-operation: the shadow request is discarded, cfg_* return to DEF_*, and the sequence restarts from BLANK.
- Width rules:
  - all comparisons unsigned, 11 bit
  - blank counter 4 bit, never wraps, because it clears on reaching BLANK_FRAMES-1

Test Plan:
- Reset release, BLANK_FRAMES=2 -> blank_o=1, busy_o=1, cfg=90/80/70/60. blank_o falls 1 cycle after the 2nd frame_end_i; req_ready_o=1 from then on.
- In RUN, request 1650/1280/750/720, frame_end_i 10 cycles later:
  - busy_o=1 from the next cycle
  - gen_restart_o pulses 1 cycle after frame_end_i
  - cfg_* = 1650/1280/750/720 from the following cycle
  - blank_o=1 for 2 frames, then RUN
- Invalid request col_active=90, col_total=90 -> err_o high exactly 1 cycle; cfg_* unchanged; state RUN; req_ready_o stays 1.
- Request accepted in the same cycle as frame_end_i -> no APPLY on that pulse; APPLY follows the next frame_end_i.
- req_valid_i held during BLANK with new values -> ready=0 throughout; accepted on the first RUN cycle; second change sequence runs normally.
- rst_ni asserted during WAIT_EOF after a valid request -> cfg_* = DEF_* immediately; no gen_restart_o pulse; blank_o=1; pending request lost.
